imm_gen_pipe: RTL and testbench

Pipelined, parametrised immediate generator for the RV32/RV64 datapath. Accepts a full 32-bit instruction, a 3-bit format code and its PC through a valid/ready handshake. It produces the sign- or zero-extended XLEN immediate, imm-4, branch/jump target (pc+imm) and link address (pc+4) two cycles later. It sits between decode and execute, with backpressure and flush support.

---
 rtl/imm_pkg.sv | 17 +
 rtl/imm_extend.sv | 37 +++
 rtl/imm_gen_pipe.sv | 110 +++++++++++
 tb/tb_imm_gen_pipe.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared type codes and constants for the pipelined immediate generator.
package imm_pkg;

  localparam int TYPE_W = 3;

  localparam logic [TYPE_W-1:0] IMM_I        = 3'd0;
  localparam logic [TYPE_W-1:0] IMM_I_SHIFT  = 3'd1;
  localparam logic [TYPE_W-1:0] IMM_S        = 3'd2;
  localparam logic [TYPE_W-1:0] IMM_B        = 3'd3;
  localparam logic [TYPE_W-1:0] IMM_J        = 3'd4;
  localparam logic [TYPE_W-1:0] IMM_U        = 3'd5;
  localparam logic [TYPE_W-1:0] IMM_CSR_ZIMM = 3'd6;
  localparam logic [TYPE_W-1:0] IMM_NONE     = 3'd7;

  localparam int PC_INC = 4;

endpackage

// File: rtl/imm_extend.sv
// Combinational immediate extraction and XLEN sign/zero extension.
module imm_extend
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]       instr,
  input  logic [TYPE_W-1:0] imm_type,
  output logic [XLEN-1:0]   imm,
  output logic              illegal
);

  logic s;
  assign s = instr[31];

  // Opcode bits never influence the immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (imm_type)
      IMM_I:        imm = {{(XLEN-12){s}}, instr[31:20]};
      IMM_I_SHIFT:  imm = (XLEN == 64) ? {{(XLEN-6){1'b0}}, instr[25:20]}
                                       : {{(XLEN-5){1'b0}}, instr[24:20]};
      IMM_S:        imm = {{(XLEN-12){s}}, instr[31:25], instr[11:7]};
      IMM_B:        imm = {{(XLEN-12){s}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:        imm = {{(XLEN-20){s}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      // Bit 31 stays in place and also fills everything above it on RV64.
      IMM_U:        imm = {{(XLEN-31){s}}, instr[30:12], 12'd0};
      IMM_CSR_ZIMM: imm = {{(XLEN-5){1'b0}}, instr[19:15]};
      default:      illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage immediate generator: extend -> stage 1 -> adders -> stage 2 (optionally registered).
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit OUT_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [TYPE_W-1:0] in_type,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_imm_m4,
  output logic [XLEN-1:0]   out_target,
  output logic [XLEN-1:0]   out_link,
  output logic              out_illegal
);

  // Handshake: a beat transfers on a rising edge where valid && ready are both high.
  // Once valid is raised its payload is held until it transfers; ready never
  // depends on the same-side valid. flush discards everything in flight and
  // also the input beat offered in that cycle.

  logic [XLEN-1:0] ext_imm;
  logic            ext_illegal;

  imm_extend #(.XLEN(XLEN)) u_extend (
    .instr    (in_instr),
    .imm_type (in_type),
    .imm      (ext_imm),
    .illegal  (ext_illegal)
  );

  logic            s1_valid;
  logic [XLEN-1:0] s1_imm;
  logic [XLEN-1:0] s1_pc;
  logic            s1_illegal;

  logic s1_adv;
  logic s2_adv;
  logic accept;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign accept   = in_valid && in_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_imm     <= '0;
      s1_pc      <= '0;
      s1_illegal <= 1'b0;
    end else begin
      if (flush)       s1_valid <= 1'b0;
      else if (s1_adv) s1_valid <= in_valid;
      if (accept) begin
        s1_imm     <= ext_imm;
        s1_pc      <= in_pc;
        s1_illegal <= ext_illegal;
      end
    end
  end

  logic [XLEN-1:0] s2_imm_m4;
  logic [XLEN-1:0] s2_target;
  logic [XLEN-1:0] s2_link;

  assign s2_imm_m4 = s1_imm + ({XLEN{1'b1}} << 2);
  assign s2_target = s1_pc + s1_imm;
  assign s2_link   = s1_pc + XLEN'(PC_INC);

  if (OUT_REG) begin : g_out_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_valid   <= 1'b0;
        out_imm     <= '0;
        out_imm_m4  <= '0;
        out_target  <= '0;
        out_link    <= '0;
        out_illegal <= 1'b0;
      end else begin
        if (flush)       out_valid <= 1'b0;
        else if (s2_adv) out_valid <= s1_valid;
        // Only a real stage-1 entry overwrites data, so stalled outputs never glitch.
        if (s2_adv && s1_valid) begin
          out_imm     <= s1_imm;
          out_imm_m4  <= s2_imm_m4;
          out_target  <= s2_target;
          out_link    <= s2_link;
          out_illegal <= s1_illegal;
        end
      end
    end
  end else begin : g_out_comb
    assign out_valid   = s1_valid;
    assign out_imm     = s1_imm;
    assign out_imm_m4  = s2_imm_m4;
    assign out_target  = s2_target;
    assign out_link    = s2_link;
    assign out_illegal = s1_illegal;
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: RV32 registered-output instance and RV64 single-stage instance.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  localparam int AW = 32;
  localparam int BW = 64;
  localparam int AV = 4*AW + 1;
  localparam int BV = 4*BW + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // RV32, OUT_REG=1
  logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
  logic [31:0]   a_in_instr;
  logic [2:0]    a_in_type;
  logic [AW-1:0] a_in_pc, a_out_imm, a_out_imm_m4, a_out_target, a_out_link;

  // RV64, OUT_REG=0
  logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
  logic [31:0]   b_in_instr;
  logic [2:0]    b_in_type;
  logic [BW-1:0] b_in_pc, b_out_imm, b_out_imm_m4, b_out_target, b_out_link;

  logic rr_en = 1'b0;
  logic rr_bit = 1'b1;
  logic ready_set = 1'b1;
  assign a_out_ready = rr_en ? rr_bit : ready_set;
  always @(posedge clk) rr_bit <= ($urandom_range(0, 3) != 0);

  imm_gen_pipe #(.XLEN(AW), .OUT_REG(1'b1)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr),
    .in_type(a_in_type), .in_pc(a_in_pc),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_imm(a_out_imm),
    .out_imm_m4(a_out_imm_m4), .out_target(a_out_target), .out_link(a_out_link),
    .out_illegal(a_out_illegal)
  );

  imm_gen_pipe #(.XLEN(BW), .OUT_REG(1'b0)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr),
    .in_type(b_in_type), .in_pc(b_in_pc),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm),
    .out_imm_m4(b_out_imm_m4), .out_target(b_out_target), .out_link(b_out_link),
    .out_illegal(b_out_illegal)
  );

  // scoreboard
  logic [AV-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [263:0] obs, input logic [263:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [AV-1:0] a_pack(input logic ill, input logic [AW-1:0] link,
      input logic [AW-1:0] target, input logic [AW-1:0] m4, input logic [AW-1:0] imm);
    return {ill, link, target, m4, imm};
  endfunction

  function automatic logic [BV-1:0] b_pack(input logic ill, input logic [BW-1:0] link,
      input logic [BW-1:0] target, input logic [BW-1:0] m4, input logic [BW-1:0] imm);
    return {ill, link, target, m4, imm};
  endfunction

  function automatic logic [AW-1:0] model_imm(input logic [31:0] i, input logic [2:0] t);
    case (t)
      3'd0:    return {{20{i[31]}}, i[31:20]};
      3'd1:    return {27'd0, i[24:20]};
      3'd2:    return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd3:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd4:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'd5:    return {i[31:12], 12'd0};
      3'd6:    return {27'd0, i[19:15]};
      default: return '0;
    endcase
  endfunction

  function automatic logic [AV-1:0] model_vec(input logic [31:0] i, input logic [2:0] t,
      input logic [AW-1:0] pc);
    logic [AW-1:0] imm;
    imm = model_imm(i, t);
    return a_pack(t == 3'd7, pc + 32'd4, pc + imm, imm - 32'd4, imm);
  endfunction

  // output monitor: head of queue must match whenever an entry is shown
  always @(negedge clk) begin
    if (!rst && a_out_valid) begin
      if (exp_q.size() == 0) begin
        if (a_out_ready) chk("a_unexpected_out", a_out_valid, 1'b0);
      end else begin
        chk("a_out", {a_out_illegal, a_out_link, a_out_target, a_out_imm_m4, a_out_imm}, exp_q[0]);
        if (a_out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // driver tasks (entered and left at posedge+1)
  task automatic a_send(input logic [31:0] instr, input logic [2:0] t, input logic [AW-1:0] pc,
      input logic [AV-1:0] exp, input bit push, input int rel);
    a_in_valid = 1'b1;
    a_in_instr = instr;
    a_in_type  = t;
    a_in_pc    = pc;
    for (int w = 0; w < 64; w++) begin
      @(negedge clk);
      if (a_in_ready) begin
        if (push) exp_q.push_back(exp);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
      if (w + 1 == rel) ready_set = 1'b1;
    end
    chk("a_accept_timeout", a_in_ready, 1'b1);
  endtask

  task automatic a_drain();
    for (int k = 0; k < 300; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("a_drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic b_one(input string tag, input logic [31:0] instr, input logic [2:0] t,
      input logic [BW-1:0] pc, input logic [BV-1:0] exp);
    b_in_valid = 1'b1;
    b_in_instr = instr;
    b_in_type  = t;
    b_in_pc    = pc;
    @(negedge clk);
    chk({tag, "_ready"}, b_in_ready, 1'b1);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    @(negedge clk);
    chk(tag, {b_out_valid, b_out_illegal, b_out_link, b_out_target, b_out_imm_m4, b_out_imm},
        {1'b1, exp});
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    a_flush = 1'b0; a_in_valid = 1'b0; a_in_instr = '0; a_in_type = '0; a_in_pc = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_instr = '0; b_in_type = '0; b_in_pc = '0;
    b_out_ready = 1'b1;

    // reset state
    #2;
    chk("a_rst_out_valid", a_out_valid, 1'b0);
    chk("b_rst_out_valid", b_out_valid, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("a_post_rst_in_ready", a_in_ready, 1'b1);
    chk("a_post_rst_imm", {a_out_illegal, a_out_imm}, '0);
    chk("b_post_rst_in_ready", b_in_ready, 1'b1);
    chk("b_post_rst_imm", {b_out_illegal, b_out_imm}, '0);
    @(posedge clk); #1;

    // latency: I type emerges two edges after acceptance
    a_send(32'hFFF00093, IMM_I, 32'h0, a_pack(1'b0, 32'h4, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'hFFFFFFFF), 1, 0);
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("a_latency_1", a_out_valid, 1'b0);
    @(negedge clk);
    chk("a_latency_2", a_out_valid, 1'b1);
    @(posedge clk); #1;

    // back-to-back directed formats, including pc wrap
    a_send(32'hFE000EE3, IMM_B, 32'h100, a_pack(1'b0, 32'h104, 32'hFC, 32'hFFFFFFF8, 32'hFFFFFFFC), 1, 0);
    a_send(32'hFE112E23, IMM_S, 32'h40, a_pack(1'b0, 32'h44, 32'h3C, 32'hFFFFFFF8, 32'hFFFFFFFC), 1, 0);
    a_send(32'h008000EF, IMM_J, 32'h200, a_pack(1'b0, 32'h204, 32'h208, 32'h4, 32'h8), 1, 0);
    a_send(32'h800002B7, IMM_U, 32'h10, a_pack(1'b0, 32'h14, 32'h80000010, 32'h7FFFFFFC, 32'h80000000), 1, 0);
    a_send(32'h340FD073, IMM_CSR_ZIMM, 32'h20, a_pack(1'b0, 32'h24, 32'h3F, 32'h1B, 32'h1F), 1, 0);
    a_send(32'h03F0D093, IMM_I_SHIFT, 32'h0, a_pack(1'b0, 32'h4, 32'h1F, 32'h1B, 32'h1F), 1, 0);
    a_send(32'h008000EF, IMM_J, 32'hFFFFFFFC, a_pack(1'b0, 32'h0, 32'h4, 32'h4, 32'h8), 1, 0);
    a_in_valid = 1'b0;
    a_drain();

    // backpressure: two entries fill the pipe, third waits until out_ready returns
    ready_set = 1'b0;
    a_send(32'h12345013, IMM_I, 32'h1000, model_vec(32'h12345013, IMM_I, 32'h1000), 1, 0);
    a_send(32'h80A12123, IMM_S, 32'h1004, model_vec(32'h80A12123, IMM_S, 32'h1004), 1, 0);
    @(negedge clk);
    chk("a_bp_in_ready_low", a_in_ready, 1'b0);
    chk("a_bp_out_valid", a_out_valid, 1'b1);
    @(posedge clk); #1;
    a_send(32'h7E208863, IMM_B, 32'h1008, model_vec(32'h7E208863, IMM_B, 32'h1008), 1, 4);
    a_in_valid = 1'b0;
    a_drain();

    // random stimulus with random downstream stalls
    rr_en = 1'b1;
    for (int n = 0; n < 24; n++) begin
      logic [31:0] ri;
      logic [2:0]  rt;
      logic [31:0] rp;
      ri = $urandom;
      rt = 3'($urandom_range(0, 7));
      rp = $urandom;
      a_send(ri, rt, rp, model_vec(ri, rt, rp), 1, 0);
    end
    a_in_valid = 1'b0;
    a_drain();
    rr_en = 1'b0;
    ready_set = 1'b1;

    // flush with two in flight plus a presented entry
    ready_set = 1'b0;
    a_send(32'h00500093, IMM_I, 32'h2000, '0, 0, 0);
    a_send(32'h00600093, IMM_I, 32'h2004, '0, 0, 0);
    a_in_instr = 32'h00700093;
    a_in_pc    = 32'h2008;
    a_flush    = 1'b1;
    @(posedge clk); #1;
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("a_flush_out_valid", a_out_valid, 1'b0);
    chk("a_flush_in_ready", a_in_ready, 1'b1);
    @(posedge clk); #1;
    ready_set = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    a_send(32'hFFFFFFFF, IMM_NONE, 32'h300, a_pack(1'b1, 32'h304, 32'h300, 32'hFFFFFFFC, 32'h0), 1, 0);
    a_in_valid = 1'b0;
    a_drain();

    // asynchronous reset in the middle of a stall
    ready_set = 1'b0;
    a_send(32'h00100093, IMM_I, 32'h3000, '0, 0, 0);
    a_send(32'h00200093, IMM_I, 32'h3004, '0, 0, 0);
    a_in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("a_async_rst_out_valid", a_out_valid, 1'b0);
    chk("a_async_rst_in_ready", a_in_ready, 1'b1);
    chk("a_async_rst_imm", a_out_imm, '0);
    #3 rst = 1'b0;
    ready_set = 1'b1;
    @(negedge clk);
    chk("a_after_rst_out_valid", a_out_valid, 1'b0);
    @(posedge clk); #1;
    a_send(32'h02A00093, IMM_I, 32'h40, a_pack(1'b0, 32'h44, 32'h6A, 32'h26, 32'h2A), 1, 0);
    a_in_valid = 1'b0;
    a_drain();

    // RV64 single-stage instance
    b_one("b_u_sext", 32'h800002B7, IMM_U, 64'h1000,
          b_pack(1'b0, 64'h1004, 64'hFFFFFFFF80001000, 64'hFFFFFFFF7FFFFFFC, 64'hFFFFFFFF80000000));
    b_one("b_shamt6", 32'h03F0D093, IMM_I_SHIFT, 64'h0,
          b_pack(1'b0, 64'h4, 64'h3F, 64'h3B, 64'h3F));
    b_one("b_i_neg", 32'hFFF00093, IMM_I, 64'h8,
          b_pack(1'b0, 64'hC, 64'h7, 64'hFFFFFFFFFFFFFFFB, 64'hFFFFFFFFFFFFFFFF));
    b_one("b_b_neg", 32'hFE000EE3, IMM_B, 64'h100,
          b_pack(1'b0, 64'h104, 64'hFC, 64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFFFC));
    b_one("b_j_wrap", 32'h008000EF, IMM_J, 64'hFFFFFFFFFFFFFFFC,
          b_pack(1'b0, 64'h0, 64'h4, 64'h4, 64'h8));
    b_one("b_none", 32'h12345678, IMM_NONE, 64'h500,
          b_pack(1'b1, 64'h504, 64'h500, 64'hFFFFFFFFFFFFFFFC, 64'h0));

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
